// File: rtl/btn_select_latch.sv
`default_nettype none
// ============================================================================
//  Module      : btn_select_latch
//  Description : N-channel push-button front end. Each raw input passes
//                through a 2-FF synchroniser and a debounce counter, and
//                every debounced rising edge becomes a press event. The
//                selection is held as a one-hot code with lowest-index
//                priority, an optional toggle-off mode and a synchronous
//                clear. An encoded index, a valid flag and a change strobe
//                are provided for downstream logic.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_select_latch #(
   parameter int N_BTN     = 4,
   parameter int DB_CYCLES = 16,
   parameter int CNT_W     = 5,
   parameter int IDX_W     = 2,
   parameter int TOGGLE_EN = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_in,
   input  logic             clear,
   output logic [N_BTN-1:0] btn_db,
   output logic [N_BTN-1:0] sel,
   output logic [IDX_W-1:0] sel_idx,
   output logic             sel_valid,
   output logic             changed
);

   // Counter value on which the next disagreeing cycle completes the hold.
   localparam logic [CNT_W-1:0] C_DB_LAST = CNT_W'(DB_CYCLES - 1);

   logic [N_BTN-1:0] sync1_q, sync1_d;
   logic [N_BTN-1:0] sync2_q, sync2_d;
   logic [N_BTN-1:0] btn_db_q, btn_db_d;
   logic [N_BTN-1:0] btn_db_prev_q, btn_db_prev_d;
   logic [CNT_W-1:0] cnt_q [N_BTN];
   logic [CNT_W-1:0] cnt_d [N_BTN];

   logic [N_BTN-1:0] sel_q, sel_d;
   logic [IDX_W-1:0] sel_idx_q, sel_idx_d;
   logic             sel_valid_q, sel_valid_d;
   logic             changed_q, changed_d;

   logic [N_BTN-1:0] press;
   logic             any_press;
   logic [IDX_W-1:0] win;
   logic [N_BTN-1:0] win_onehot;

   // Synchroniser stages and previous-level register simply shift along.
   always_comb begin
      sync1_d       = btn_in;
      sync2_d       = sync1_q;
      btn_db_prev_d = btn_db_q;
   end

   // Debounce: count cycles of disagreement, accept the new level once it
   // has held DB_CYCLES cycles; any agreement in between restarts the count.
   always_comb begin
      btn_db_d = btn_db_q;
      for (int i = 0; i < N_BTN; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != btn_db_q[i]) begin
            if (cnt_q[i] == C_DB_LAST) begin
               btn_db_d[i] = ~btn_db_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Press detection, lowest-index winner and selection next state.
   always_comb begin
      press      = btn_db_q & ~btn_db_prev_q;
      any_press  = |press;
      win        = '0;
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (press[i]) begin
            win = IDX_W'(i);
         end
      end
      win_onehot      = '0;
      win_onehot[win] = 1'b1;

      sel_d     = sel_q;
      sel_idx_d = sel_idx_q;
      changed_d = 1'b0;
      if (clear) begin
         // Clear wins over any press in the same cycle; the press is dropped.
         sel_d     = '0;
         sel_idx_d = '0;
         changed_d = |sel_q;
      end else if (any_press) begin
         if (sel_q[win]) begin
            if (TOGGLE_EN != 0) begin
               sel_d     = '0;
               sel_idx_d = '0;
               changed_d = 1'b1;
            end
         end else begin
            sel_d     = win_onehot;
            sel_idx_d = win;
            changed_d = 1'b1;
         end
      end
      sel_valid_d = |sel_d;
   end

   // Synchroniser, debounce and previous-level registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q       <= '0;
         sync2_q       <= '0;
         btn_db_q      <= '0;
         btn_db_prev_q <= '0;
         for (int i = 0; i < N_BTN; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         btn_db_q      <= btn_db_d;
         btn_db_prev_q <= btn_db_prev_d;
         for (int i = 0; i < N_BTN; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Selection outputs are registered together so they always agree.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q       <= '0;
         sel_idx_q   <= '0;
         sel_valid_q <= 1'b0;
         changed_q   <= 1'b0;
      end else begin
         sel_q       <= sel_d;
         sel_idx_q   <= sel_idx_d;
         sel_valid_q <= sel_valid_d;
         changed_q   <= changed_d;
      end
   end

   assign btn_db    = btn_db_q;
   assign sel       = sel_q;
   assign sel_idx   = sel_idx_q;
   assign sel_valid = sel_valid_q;
   assign changed   = changed_q;

endmodule
`default_nettype wire

// File: tb/tb_btn_select_latch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_select_latch
//  Description : Self-checking bench for btn_select_latch. Two instances
//                (toggle off / toggle on) share the same stimulus and are
//                compared every cycle against a window-based model, with
//                additional hand-computed checkpoints.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_select_latch;

   localparam int N  = 4;
   localparam int DB = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] btn_in;
   logic         clear;

   logic [N-1:0] o0_db, o0_sel, o1_db, o1_sel;
   logic [1:0]   o0_idx, o1_idx;
   logic         o0_valid, o1_valid, o0_chg, o1_chg;

   int n_tests = 0;
   int n_fail  = 0;

   btn_select_latch #(.N_BTN(N), .DB_CYCLES(DB), .CNT_W(3), .IDX_W(2), .TOGGLE_EN(0)) u_t0 (
      .clk(clk), .rst(rst), .btn_in(btn_in), .clear(clear),
      .btn_db(o0_db), .sel(o0_sel), .sel_idx(o0_idx), .sel_valid(o0_valid), .changed(o0_chg)
   );

   btn_select_latch #(.N_BTN(N), .DB_CYCLES(DB), .CNT_W(3), .IDX_W(2), .TOGGLE_EN(1)) u_t1 (
      .clk(clk), .rst(rst), .btn_in(btn_in), .clear(clear),
      .btn_db(o1_db), .sel(o1_sel), .sel_idx(o1_idx), .sel_valid(o1_valid), .changed(o1_chg)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------- model
   // A level is accepted when the last DB synchronised samples all differ
   // from the current debounced level. Selection is kept as an integer
   // index (-1 = none) per instance.
   logic [N-1:0] m_s1, m_s2, m_db, m_prev;
   logic [N-1:0] m_hist [DB];
   int           m_sel [2];
   bit           m_chg [2];
   logic [N-1:0] m_old_sync, m_old_db, m_old_prev, m_press;
   int           m_w;
   bit           m_all;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_s1 = '0; m_s2 = '0; m_db = '0; m_prev = '0;
         for (int j = 0; j < DB; j++) m_hist[j] = '0;
         for (int d = 0; d < 2; d++) begin m_sel[d] = -1; m_chg[d] = 0; end
      end else begin
         m_old_sync = m_s2;
         m_old_db   = m_db;
         m_old_prev = m_prev;
         m_s2 = m_s1;
         m_s1 = btn_in;
         for (int j = DB - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
         m_hist[0] = m_old_sync;
         for (int c = 0; c < N; c++) begin
            m_all = 1;
            for (int j = 0; j < DB; j++) if (m_hist[j][c] == m_old_db[c]) m_all = 0;
            if (m_all) m_db[c] = ~m_old_db[c];
         end
         m_prev  = m_old_db;
         m_press = m_old_db & ~m_old_prev;
         m_w = -1;
         for (int c = N - 1; c >= 0; c--) if (m_press[c]) m_w = c;
         for (int d = 0; d < 2; d++) begin
            m_chg[d] = 0;
            if (clear) begin
               m_chg[d] = (m_sel[d] != -1);
               m_sel[d] = -1;
            end else if (m_w != -1) begin
               if (m_sel[d] == m_w) begin
                  if (d == 1) begin m_sel[d] = -1; m_chg[d] = 1; end
               end else begin
                  m_sel[d] = m_w; m_chg[d] = 1;
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------- checks
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_dut(input int d, input logic [N-1:0] db, input logic [N-1:0] s,
                          input logic [1:0] idx, input logic v, input logic ch);
      logic [N-1:0] es;
      es = (m_sel[d] < 0) ? '0 : (N'(1) << m_sel[d]);
      chk($sformatf("model_db%0d", d),    32'(db),  32'(m_db));
      chk($sformatf("model_sel%0d", d),   32'(s),   32'(es));
      chk($sformatf("model_idx%0d", d),   32'(idx), (m_sel[d] < 0) ? 32'd0 : 32'(m_sel[d]));
      chk($sformatf("model_valid%0d", d), 32'(v),   32'(m_sel[d] >= 0));
      chk($sformatf("model_chg%0d", d),   32'(ch),  32'(m_chg[d]));
   endtask

   // Compare both instances against the model away from the active edge.
   always @(negedge clk) begin
      cmp_dut(0, o0_db, o0_sel, o0_idx, o0_valid, o0_chg);
      cmp_dut(1, o1_db, o1_sel, o1_idx, o1_valid, o1_chg);
   end

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      rst = 1'b1; btn_in = '0; clear = 1'b0;
      edges(3);
      chk("rst_sel",   32'(o0_sel),   32'h0);
      chk("rst_db",    32'(o0_db),    32'h0);
      chk("rst_valid", 32'(o0_valid), 32'h0);
      chk("rst_chg",   32'(o1_chg),   32'h0);
      rst = 1'b0;
      edges(3);

      // single press with latency checkpoints
      btn_in = 4'b0100;
      edges(5);
      chk("t1_db_early", 32'(o0_db), 32'h0);
      edges(1);
      chk("t1_db",     32'(o0_db), 32'h4);
      chk("t1_sel_pre", 32'(o0_sel), 32'h0);
      edges(1);
      chk("t1_sel",   32'(o0_sel),   32'h4);
      chk("t1_idx",   32'(o0_idx),   32'h2);
      chk("t1_valid", 32'(o0_valid), 32'h1);
      chk("t1_chg",   32'(o0_chg),   32'h1);
      edges(1);
      chk("t1_chg_off", 32'(o0_chg), 32'h0);
      btn_in = '0;
      edges(12);
      chk("t1_rel_sel", 32'(o0_sel), 32'h4);

      // glitch rejection, then accepted hold
      btn_in = 4'b0010;
      edges(3);
      btn_in = '0;
      edges(12);
      chk("t2_glitch_db",  32'(o0_db),  32'h0);
      chk("t2_glitch_sel", 32'(o0_sel), 32'h4);
      btn_in = 4'b0010;
      edges(7);
      chk("t2_sel", 32'(o0_sel), 32'h2);
      chk("t2_idx", 32'(o1_idx), 32'h1);
      btn_in = '0;
      edges(12);

      // clear with selection, then simultaneous presses
      clear = 1'b1;
      edges(1);
      clear = 1'b0;
      chk("t3_clr_sel", 32'(o0_sel), 32'h0);
      chk("t3_clr_chg", 32'(o0_chg), 32'h1);
      edges(1);
      btn_in = 4'b1010;
      edges(7);
      chk("t3_pri_sel", 32'(o0_sel), 32'h2);
      chk("t3_pri_idx", 32'(o0_idx), 32'h1);
      btn_in = '0;
      edges(12);
      btn_in = 4'b1000;
      edges(7);
      chk("t3_b3_sel", 32'(o0_sel), 32'h8);
      chk("t3_b3_idx", 32'(o0_idx), 32'h3);
      chk("t3_b3_chg", 32'(o0_chg), 32'h1);
      edges(1);
      chk("t3_b3_chg_off", 32'(o0_chg), 32'h0);
      btn_in = '0;
      edges(12);

      // re-press of selected button 0
      btn_in = 4'b0001;
      edges(7);
      chk("t4_sel0", 32'(o1_sel), 32'h1);
      btn_in = '0;
      edges(12);
      btn_in = 4'b0001;
      edges(7);
      chk("t4_hold_sel",   32'(o0_sel),   32'h1);
      chk("t4_hold_chg",   32'(o0_chg),   32'h0);
      chk("t4_tog_sel",    32'(o1_sel),   32'h0);
      chk("t4_tog_idx",    32'(o1_idx),   32'h0);
      chk("t4_tog_valid",  32'(o1_valid), 32'h0);
      chk("t4_tog_chg",    32'(o1_chg),   32'h1);
      edges(1);
      chk("t4_tog_chg_off", 32'(o1_chg), 32'h0);
      btn_in = '0;
      edges(12);

      // clear coincident with a press event
      btn_in = 4'b0100;
      edges(7);
      chk("t5_setup", 32'(o1_sel), 32'h4);
      btn_in = '0;
      edges(12);
      btn_in = 4'b0001;
      edges(6);
      clear = 1'b1;
      edges(1);
      clear = 1'b0;
      chk("t5_sel", 32'(o0_sel), 32'h0);
      chk("t5_chg", 32'(o0_chg), 32'h1);
      edges(1);
      chk("t5_dropped", 32'(o0_sel), 32'h0);
      clear = 1'b1;
      edges(1);
      clear = 1'b0;
      chk("t5_clr_empty_chg", 32'(o0_chg), 32'h0);
      btn_in = '0;
      edges(12);

      // reset in the middle of a debounce
      btn_in = 4'b0100;
      edges(7);
      btn_in = '0;
      edges(12);
      chk("t6_setup", 32'(o0_sel), 32'h4);
      btn_in = 4'b0001;
      edges(4);
      rst = 1'b1;
      #1;
      chk("t6_rst_sel",   32'(o0_sel),   32'h0);
      chk("t6_rst_idx",   32'(o0_idx),   32'h0);
      chk("t6_rst_valid", 32'(o1_valid), 32'h0);
      edges(2);
      rst = 1'b0;
      edges(6);
      chk("t6_sel_early", 32'(o0_sel), 32'h0);
      edges(1);
      chk("t6_sel", 32'(o0_sel), 32'h1);
      chk("t6_chg", 32'(o1_chg), 32'h1);
      btn_in = '0;
      edges(5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
